// File: rtl/alu_fifo_sequencer.sv
// Sequences one ALU transaction: pops opcode/A and B from the input FIFO, launches the ALU,
// waits for done (bounded by TIMEOUT) and pushes the result into the output FIFO.
module alu_fifo_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int OP_WIDTH   = 4,
  parameter int TIMEOUT    = 16,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           en,
  input  logic                           in_empty,
  input  logic [OP_WIDTH+DATA_WIDTH-1:0] in_data,
  output logic                           in_r_en,
  output logic [OP_WIDTH-1:0]            alu_op,
  output logic [DATA_WIDTH-1:0]          alu_a,
  output logic [DATA_WIDTH-1:0]          alu_b,
  output logic                           alu_start,
  input  logic                           alu_done,
  input  logic [DATA_WIDTH-1:0]          alu_result,
  input  logic                           out_full,
  output logic                           out_w_en,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic                           busy,
  output logic                           timeout_err,
  output logic [CNT_WIDTH-1:0]           done_cnt,
  output logic [CNT_WIDTH-1:0]           err_cnt
);

  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [3:0] {
    IDLE, RD_A, LD_A, WT_B, RD_B, LD_B, EXEC, WAIT, WR
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   tmo_cnt;
  logic            tmo_expired;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  assign tmo_expired = (tmo_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // LD states sit between the two pops so a lagging empty flag is never trusted twice.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (en && !in_empty) state_d = RD_A;
      RD_A: state_d = LD_A;
      LD_A: state_d = WT_B;
      WT_B: if (!in_empty) state_d = RD_B;
      RD_B: state_d = LD_B;
      LD_B: state_d = EXEC;
      EXEC: state_d = WAIT;
      WAIT: begin
        if (alu_done)         state_d = WR;
        else if (tmo_expired) state_d = IDLE;
      end
      WR:   if (!out_full) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign in_r_en   = (state_q == RD_A) || (state_q == RD_B);
  assign alu_start = (state_q == EXEC);
  assign busy      = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_op   <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      out_data <= '0;
    end else begin
      if (state_q == LD_A) begin
        alu_op <= in_data[OP_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
        alu_a  <= in_data[DATA_WIDTH-1:0];
      end
      if (state_q == LD_B) alu_b <= in_data[DATA_WIDTH-1:0];
      if (state_q == WAIT && alu_done) out_data <= alu_result;
    end
  end

  // Done has priority over expiry in the same WAIT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
      err_cnt     <= '0;
      done_cnt    <= '0;
      out_w_en    <= 1'b0;
    end else begin
      out_w_en <= (state_q == WR) && !out_full;
      if (state_q == EXEC) tmo_cnt <= '0;
      if (state_q == WAIT && !alu_done) begin
        if (tmo_expired) begin
          timeout_err <= 1'b1;
          err_cnt     <= sat_inc(err_cnt);
        end else begin
          tmo_cnt <= tmo_cnt + TW'(1);
        end
      end
      if (state_q == WR && !out_full) done_cnt <= done_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_alu_fifo_sequencer.sv
// Directed bench for alu_fifo_sequencer with a behavioural input FIFO and a simple adder ALU.
module tb_alu_fifo_sequencer;
  localparam int DW = 8;
  localparam int OW = 4;
  localparam int CW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          out_full = 1'b0;
  logic          alu_resp = 1'b1;
  logic          in_empty = 1'b1;
  logic [OW+DW-1:0] in_data = '0;
  logic          alu_done = 1'b0;
  logic [DW-1:0] alu_result = '0;
  logic          in_r_en, alu_start, out_w_en, busy, timeout_err;
  logic [OW-1:0] alu_op;
  logic [DW-1:0] alu_a, alu_b, out_data;
  logic [CW-1:0] done_cnt, err_cnt;

  alu_fifo_sequencer #(.DATA_WIDTH(DW), .OP_WIDTH(OW), .TIMEOUT(16), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in_empty(in_empty), .in_data(in_data),
    .in_r_en(in_r_en), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_start(alu_start), .alu_done(alu_done), .alu_result(alu_result),
    .out_full(out_full), .out_w_en(out_w_en), .out_data(out_data), .busy(busy),
    .timeout_err(timeout_err), .done_cnt(done_cnt), .err_cnt(err_cnt)
  );

  // Input FIFO model: registered empty flag, read data valid the cycle after a pop.
  logic [OW+DW-1:0] fifo_mem [0:1023];
  logic [9:0] wp = '0;
  logic [9:0] rp = '0;
  always @(posedge clk) begin
    if (in_r_en && rp != wp) begin
      in_data  <= fifo_mem[rp];
      rp       <= rp + 10'd1;
      in_empty <= (rp + 10'd1 == wp);
    end else begin
      in_empty <= (rp == wp);
    end
  end

  // ALU model: result = a + b, done one cycle after start when enabled.
  always @(posedge clk) begin
    alu_done   <= alu_start && alu_resp;
    alu_result <= alu_a + alu_b;
  end

  int cyc = 0, rd_n = 0, wr_n = 0, st_n = 0;
  int rd_prev = 0, rd_last = 0, wr_cyc = 0, st_cyc = 0;
  int consec = 0, bp = 0, emp = 0;
  logic [DW-1:0] wr_data = '0;
  logic prev_r = 1'b0, full_q = 1'b0, empty_q = 1'b1;

  always @(posedge clk) begin
    full_q  <= out_full;
    empty_q <= in_empty;
  end

  always @(negedge clk) begin
    cyc    <= cyc + 1;
    prev_r <= in_r_en;
    if (in_r_en) begin
      rd_n    <= rd_n + 1;
      rd_prev <= rd_last;
      rd_last <= cyc;
      if (prev_r)  consec <= consec + 1;
      if (empty_q) emp <= emp + 1;
    end
    if (out_w_en) begin
      wr_n    <= wr_n + 1;
      wr_cyc  <= cyc;
      wr_data <= out_data;
      if (full_q) bp <= bp + 1;
    end
    if (alu_start) begin
      st_n   <= st_n + 1;
      st_cyc <= cyc;
    end
  end

  int total = 0;
  int bad = 0;

  task automatic push(input logic [OW+DW-1:0] w);
    fifo_mem[wp] = w;
    wp = wp + 10'd1;
  endtask

  task automatic wait_wr(input int w0, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (wr_n != w0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_start(input int s0, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (st_n != s0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    en = 1'($urandom); out_full = 1'($urandom); alu_resp = 1'($urandom);
    repeat (3) @(negedge clk);
    total++; if (in_r_en !== 1'b0) begin bad++; $display("FAIL rst_in_r_en got=%b want=0", in_r_en); end
    total++; if (out_w_en !== 1'b0) begin bad++; $display("FAIL rst_out_w_en got=%b want=0", out_w_en); end
    total++; if (alu_start !== 1'b0) begin bad++; $display("FAIL rst_alu_start got=%b want=0", alu_start); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL rst_timeout_err got=%b want=0", timeout_err); end
    total++; if (done_cnt !== 8'h00) begin bad++; $display("FAIL rst_done_cnt got=%0h want=0", done_cnt); end
    total++; if (err_cnt !== 8'h00) begin bad++; $display("FAIL rst_err_cnt got=%0h want=0", err_cnt); end
    total++; if (alu_op !== 4'h0) begin bad++; $display("FAIL rst_alu_op got=%0h want=0", alu_op); end
    total++; if (alu_a !== 8'h00) begin bad++; $display("FAIL rst_alu_a got=%0h want=0", alu_a); end
    total++; if (alu_b !== 8'h00) begin bad++; $display("FAIL rst_alu_b got=%0h want=0", alu_b); end
    total++; if (out_data !== 8'h00) begin bad++; $display("FAIL rst_out_data got=%0h want=0", out_data); end
    en = 1'b0; out_full = 1'b0; alu_resp = 1'b1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_op();
    int s0, w0;
    bit ok;
    s0 = st_n; w0 = wr_n;
    push({4'h3, 8'h12});
    push({4'hF, 8'h05});
    en = 1'b1;
    wait_wr(w0, ok);
    total++; if (!ok) begin bad++; $display("FAIL single_wait got=timeout want=write"); end
    total++; if (alu_op !== 4'h3) begin bad++; $display("FAIL single_alu_op got=%0h want=3", alu_op); end
    total++; if (alu_a !== 8'h12) begin bad++; $display("FAIL single_alu_a got=%0h want=12", alu_a); end
    total++; if (alu_b !== 8'h05) begin bad++; $display("FAIL single_alu_b got=%0h want=05", alu_b); end
    total++; if (st_n - s0 !== 1) begin bad++; $display("FAIL single_starts got=%0d want=1", st_n - s0); end
    total++; if (wr_n - w0 !== 1) begin bad++; $display("FAIL single_writes got=%0d want=1", wr_n - w0); end
    total++; if (wr_data !== 8'h17) begin bad++; $display("FAIL single_out_data got=%0h want=17", wr_data); end
    total++; if (done_cnt !== 8'd1) begin bad++; $display("FAIL single_done_cnt got=%0d want=1", done_cnt); end
    total++; if (wr_cyc - rd_prev !== 8) begin bad++; $display("FAIL single_latency got=%0d want=8", wr_cyc - rd_prev); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_after got=%b want=0", busy); end
  endtask

  task automatic test_starved();
    int r0, w0;
    bit ok;
    r0 = rd_n; w0 = wr_n;
    push({4'h5, 8'h40});
    repeat (12) @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL starved_busy got=%b want=1", busy); end
    total++; if (in_r_en !== 1'b0) begin bad++; $display("FAIL starved_in_r_en got=%b want=0", in_r_en); end
    total++; if (rd_n - r0 !== 1) begin bad++; $display("FAIL starved_reads got=%0d want=1", rd_n - r0); end
    push({4'h0, 8'h22});
    wait_wr(w0, ok);
    total++; if (!ok) begin bad++; $display("FAIL starved_wait got=timeout want=write"); end
    total++; if (wr_data !== 8'h62) begin bad++; $display("FAIL starved_out_data got=%0h want=62", wr_data); end
    total++; if (alu_op !== 4'h5) begin bad++; $display("FAIL starved_alu_op got=%0h want=5", alu_op); end
    total++; if (done_cnt !== 8'd2) begin bad++; $display("FAIL starved_done_cnt got=%0d want=2", done_cnt); end
  endtask

  task automatic test_backpressure();
    int s0, w0;
    bit ok;
    s0 = st_n; w0 = wr_n;
    out_full = 1'b1;
    push({4'h1, 8'h0A});
    push({4'h0, 8'h0B});
    wait_start(s0, ok);
    total++; if (!ok) begin bad++; $display("FAIL bp_start_wait got=timeout want=start"); end
    repeat (6) @(negedge clk);
    total++; if (wr_n !== w0) begin bad++; $display("FAIL bp_no_write got=%0d want=%0d", wr_n, w0); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL bp_busy got=%b want=1", busy); end
    out_full = 1'b0;
    @(negedge clk);
    total++; if (out_w_en !== 1'b1) begin bad++; $display("FAIL bp_w_en_pulse got=%b want=1", out_w_en); end
    total++; if (out_data !== 8'h15) begin bad++; $display("FAIL bp_out_data got=%0h want=15", out_data); end
    @(negedge clk);
    total++; if (out_w_en !== 1'b0) begin bad++; $display("FAIL bp_w_en_drop got=%b want=0", out_w_en); end
    @(negedge clk);
    total++; if (wr_n - w0 !== 1) begin bad++; $display("FAIL bp_writes got=%0d want=1", wr_n - w0); end
    total++; if (done_cnt !== 8'd3) begin bad++; $display("FAIL bp_done_cnt got=%0d want=3", done_cnt); end
  endtask

  task automatic test_timeout();
    int s0, w0, idle_cyc;
    bit ok;
    s0 = st_n; w0 = wr_n;
    alu_resp = 1'b0;
    push({4'h2, 8'h01});
    push({4'h0, 8'h02});
    wait_start(s0, ok);
    total++; if (!ok) begin bad++; $display("FAIL tmo_start_wait got=timeout want=start"); end
    wait_idle(ok);
    idle_cyc = cyc;
    total++; if (!ok) begin bad++; $display("FAIL tmo_idle_wait got=busy want=idle"); end
    total++; if (idle_cyc - st_cyc !== 17) begin bad++; $display("FAIL tmo_wait_len got=%0d want=17", idle_cyc - st_cyc); end
    total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL tmo_err_flag got=%b want=1", timeout_err); end
    total++; if (err_cnt !== 8'd1) begin bad++; $display("FAIL tmo_err_cnt got=%0d want=1", err_cnt); end
    total++; if (wr_n !== w0) begin bad++; $display("FAIL tmo_no_write got=%0d want=%0d", wr_n, w0); end
    alu_resp = 1'b1;
    push({4'h3, 8'h30});
    push({4'h0, 8'h0C});
    wait_wr(w0, ok);
    total++; if (!ok) begin bad++; $display("FAIL tmo_next_wait got=timeout want=write"); end
    total++; if (wr_data !== 8'h3C) begin bad++; $display("FAIL tmo_next_data got=%0h want=3c", wr_data); end
    total++; if (done_cnt !== 8'd4) begin bad++; $display("FAIL tmo_next_done_cnt got=%0d want=4", done_cnt); end
    total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL tmo_sticky got=%b want=1", timeout_err); end
  endtask

  task automatic test_reset_mid();
    int s0, r0, w0;
    bit ok;
    s0 = st_n;
    alu_resp = 1'b0;
    push({4'h7, 8'h01});
    push({4'h0, 8'h01});
    wait_start(s0, ok);
    total++; if (!ok) begin bad++; $display("FAIL rmid_start_wait got=timeout want=start"); end
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b want=0", busy); end
    total++; if (done_cnt !== 8'd0) begin bad++; $display("FAIL rmid_done_cnt got=%0d want=0", done_cnt); end
    total++; if (err_cnt !== 8'd0) begin bad++; $display("FAIL rmid_err_cnt got=%0d want=0", err_cnt); end
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL rmid_timeout_err got=%b want=0", timeout_err); end
    total++; if (alu_op !== 4'h0) begin bad++; $display("FAIL rmid_alu_op got=%0h want=0", alu_op); end
    r0 = rd_n; w0 = wr_n; s0 = st_n;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    alu_resp = 1'b1;
    repeat (20) @(negedge clk);
    total++; if (rd_n - r0 + wr_n - w0 + st_n - s0 !== 0) begin bad++; $display("FAIL rmid_strobes got=%0d want=0", rd_n - r0 + wr_n - w0 + st_n - s0); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_idle got=%b want=0", busy); end
  endtask

  task automatic test_done_wrap();
    int lost;
    bit ok;
    lost = 0;
    for (int i = 0; i < 255; i++) begin
      push({4'h0, 8'(i)});
      push({4'h0, 8'h01});
      wait_wr(wr_n, ok);
      if (!ok) lost++;
    end
    total++; if (done_cnt !== 8'hFF) begin bad++; $display("FAIL wrap_255 got=%0h want=ff", done_cnt); end
    push({4'h0, 8'hFF});
    push({4'h0, 8'h01});
    wait_wr(wr_n, ok);
    if (!ok) lost++;
    total++; if (lost !== 0) begin bad++; $display("FAIL wrap_lost got=%0d want=0", lost); end
    total++; if (done_cnt !== 8'h00) begin bad++; $display("FAIL wrap_256 got=%0h want=0", done_cnt); end
    total++; if (wr_data !== 8'h00) begin bad++; $display("FAIL wrap_last_data got=%0h want=0", wr_data); end
  endtask

  task automatic test_err_sat();
    int lost, w0;
    bit ok;
    lost = 0; w0 = wr_n;
    alu_resp = 1'b0;
    for (int i = 0; i < 300; i++) begin
      push({4'h1, 8'h10});
      push({4'h0, 8'h20});
      wait_start(st_n, ok);
      if (!ok) lost++;
      wait_idle(ok);
      if (!ok) lost++;
      if (i == 254) begin
        total++; if (err_cnt !== 8'hFF) begin bad++; $display("FAIL sat_255 got=%0h want=ff", err_cnt); end
      end
    end
    total++; if (lost !== 0) begin bad++; $display("FAIL sat_lost got=%0d want=0", lost); end
    total++; if (err_cnt !== 8'hFF) begin bad++; $display("FAIL sat_300 got=%0h want=ff", err_cnt); end
    total++; if (wr_n !== w0) begin bad++; $display("FAIL sat_no_write got=%0d want=%0d", wr_n, w0); end
    total++; if (done_cnt !== 8'h00) begin bad++; $display("FAIL sat_done_cnt got=%0h want=0", done_cnt); end
    alu_resp = 1'b1;
  endtask

  task automatic test_protocol();
    total++; if (consec !== 0) begin bad++; $display("FAIL proto_consec_reads got=%0d want=0", consec); end
    total++; if (emp !== 0) begin bad++; $display("FAIL proto_read_on_empty got=%0d want=0", emp); end
    total++; if (bp !== 0) begin bad++; $display("FAIL proto_write_on_full got=%0d want=0", bp); end
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_starved();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    test_done_wrap();
    test_err_sat();
    test_protocol();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_fifo_sequencer.md
Name: alu_fifo_sequencer

Overview:
Transaction controller between the ALU input FIFO, the ALU core and the ALU result FIFO.
- Pops a two-word command (opcode plus operand A, then operand B) from the input FIFO.
- Launches the ALU and waits for completion, with a timeout.
- Pushes the result into the output FIFO.
- Counts completed and timed-out transactions for the test environment.

Parameters:
DATA_WIDTH, 8, operand/result width
OP_WIDTH, 4, opcode width
TIMEOUT, 16, max cycles from alu_start to alu_done before abort (>=2)
CNT_WIDTH, 8, width of transaction/error counters

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  allows a new transaction to start from IDLE
in_empty  in  1  input FIFO empty flag (registered, may lag one cycle)
in_data  in  OP_WIDTH+DATA_WIDTH  input FIFO read data, valid the cycle after an accepted read
in_r_en  out  1  input FIFO read enable
alu_op  out  OP_WIDTH  opcode to ALU
alu_a  out  DATA_WIDTH  operand A
alu_b  out  DATA_WIDTH  operand B
alu_start  out  1  one-cycle ALU launch pulse
alu_done  in  1  ALU result valid pulse
alu_result  in  DATA_WIDTH  ALU result, sampled when alu_done=1
out_full  in  1  output FIFO full flag
out_w_en  out  1  output FIFO write enable
out_data  out  DATA_WIDTH  output FIFO write data
busy  out  1  FSM not in IDLE
timeout_err  out  1  sticky; set on ALU timeout
done_cnt  out  CNT_WIDTH  completed transactions, wraps
err_cnt  out  CNT_WIDTH  timed-out transactions, saturates at all-ones

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE.
  - All outputs, including registered alu_op/alu_a/alu_b/out_data and both counters, are 0.
  - Reset mid-transaction abandons it; no FIFO strobes are issued afterwards.
- Outputs: all are registered or decoded from state only; none depend combinationally on inputs.
- Word format:
  - First word: in_data[OP_WIDTH+DATA_WIDTH-1:DATA_WIDTH]=opcode, in_data[DATA_WIDTH-1:0]=A.
  - Second word: low DATA_WIDTH bits = B; its opcode field is ignored.
- FSM states:
  - IDLE: if en=1 and in_empty=0 -> RD_A.
  - RD_A: in_r_en=1 for exactly one cycle -> LD_A.
  - LD_A: capture opcode and A from in_data -> WT_B.
  - WT_B: wait for in_empty=0 -> RD_B. en is ignored once a transaction has started.
  - RD_B: in_r_en=1 for one cycle -> LD_B.
  - LD_B: capture B -> EXEC.
  - EXEC: alu_start=1 for one cycle; clear the timeout counter -> WAIT.
  - WAIT:
    - alu_done=1: latch alu_result into out_data -> WR.
    - Otherwise increment the timeout counter. When it reaches TIMEOUT-1 with no done: set timeout_err, increment err_cnt (saturating) -> IDLE. No write is issued.
    - alu_done in the same cycle as expiry: done wins.
  - WR: wait for out_full=0; then out_w_en=1 for one cycle, increment done_cnt (wrapping) -> IDLE.
- Read spacing:
  - in_r_en is never asserted on two consecutive cycles.
  - The one-cycle gap (LD state) absorbs the registered-empty lag, so a stale empty=0 after the last word is never used to issue a pop.
- in_r_en/out_w_en are asserted only when the corresponding flag read 0 on the preceding cycle.
- alu_done arriving outside WAIT is ignored.
- alu_op/alu_a/alu_b hold their values from LD_B until the next LD_A/LD_B.
- timeout_err clears only on reset.
- Latency with no stalls and alu_done one cycle after alu_start:
  - IDLE->RD_A->LD_A->WT_B->RD_B->LD_B->EXEC->WAIT->WR.
  - First in_r_en to out_w_en = 8 cycles.

Test Plan:
- Reset value check: with rst_n=0 at time 0 and all inputs random -> in_r_en/out_w_en/alu_start=0, busy=0, done_cnt=err_cnt=0, timeout_err=0.
- Single op: preload input FIFO with {op=4'h3,A=8'h12},{x,B=8'h05}, en=1; ALU model returns done 1 cycle after start with 8'h17 -> alu_op=3, alu_a=0x12, alu_b=0x05, one alu_start pulse; out_w_en one pulse with out_data=0x17; done_cnt=1; 8 cycles from first in_r_en to out_w_en.
- Starved operand: only first word present for 10 cycles, then second word written -> FSM holds in WT_B with in_r_en=0 and busy=1; completes normally after the write.
- Output backpressure: out_full=1 for 5 cycles while in WR -> out_w_en stays 0; it pulses once in the first cycle after out_full drops; exactly one write.
- Timeout: TIMEOUT=16, ALU never responds -> exactly 16 cycles in WAIT, then timeout_err=1, err_cnt=1, no out_w_en, return to IDLE. Next transaction with a responding ALU completes and done_cnt increments.
- Reset mid-op and wrap: assert rst_n=0 in WAIT -> immediate IDLE, counters 0, no strobes. Separately, run 256 ops with CNT_WIDTH=8 -> done_cnt wraps to 0; force 300 timeouts -> err_cnt saturates at 0xFF.
